// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout for a 160x120 3-bit framebuffer, each stored pixel shown as a 4x4 block.
// Three-stage pipeline from counter state to pins: address, RAM read, output registers.
module vga_scanout #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160,
  parameter int CH_W        = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic [14:0]     fb_addr,
  output logic            fb_rd,
  input  logic [2:0]      fb_data,
  output logic [CH_W-1:0] vga_r,
  output logic [CH_W-1:0] vga_g,
  output logic [CH_W-1:0] vga_b,
  output logic            vga_hs,
  output logic            vga_vs,
  output logic            vga_blank_n,
  output logic            vga_sync_n,
  output logic            frame_start
);

  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  // The 160-wide row base reduces to two shifts; other widths fall back to a constant multiply.
  function automatic logic [14:0] pix_addr(input logic [14:0] fx, input logic [14:0] fy);
    if (FB_W == 160) return (fy << 7) + (fy << 5) + fx;
    else             return fy * 15'(FB_W) + fx;
  endfunction

  function automatic logic [CH_W-1:0] expand_ch(input logic bit_v, input logic vld);
    return vld ? {CH_W{bit_v}} : '0;
  endfunction

  logic [9:0]  hc, vc;
  logic        h_wrap, v_wrap;
  logic        vld_p0, hs_p0, vs_p0;
  logic [14:0] fx_p0, fy_p0;
  logic        vld_p1, hs_p1, vs_p1;
  logic        vld_p2, hs_p2, vs_p2;

  assign h_wrap = (hc == H_LAST);
  assign v_wrap = (vc == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
    end else begin
      hc          <= h_wrap ? '0 : hc + 10'd1;
      if (h_wrap) vc <= v_wrap ? '0 : vc + 10'd1;
      frame_start <= h_wrap && v_wrap;
    end
  end

  // ---- S0: decode of the raw counter state
  assign vld_p0 = (hc < H_VIS_L) && (vc < V_VIS_L);
  assign hs_p0  = !((hc >= HS_FIRST) && (hc <= HS_LAST));
  assign vs_p0  = !((vc >= VS_FIRST) && (vc <= VS_LAST));
  assign fx_p0  = 15'(hc >> SCALE_SHIFT);
  assign fy_p0  = 15'(vc >> SCALE_SHIFT);

  // ---- S1: framebuffer address and read strobe; address holds through blanking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb_addr <= '0;
      vld_p1  <= 1'b0;
      hs_p1   <= 1'b1;
      vs_p1   <= 1'b1;
    end else begin
      if (vld_p0) fb_addr <= pix_addr(fx_p0, fy_p0);
      vld_p1  <= vld_p0;
      hs_p1   <= hs_p0;
      vs_p1   <= vs_p0;
    end
  end

  assign fb_rd = vld_p1;

  // ---- S2: RAM returns fb_data; flags wait alongside it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
    end else begin
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  // ---- S3: pin registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= expand_ch(fb_data[2], vld_p2);
      vga_g       <= expand_ch(fb_data[1], vld_p2);
      vga_b       <= expand_ch(fb_data[0], vld_p2);
      vga_hs      <= hs_p2;
      vga_vs      <= vs_p2;
      vga_blank_n <= vld_p2;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule
